// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising an I-fetch master (A) and a data master (B) onto a single-port memory.
// Ack lands 2 cycles after grant (one access per 4 cycles); losing requester waits and wins the next tie.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  a_req,
  input  logic [DATA_WIDTH-1:0] a_addr,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_err,
  input  logic                  b_req,
  input  logic                  b_write,
  input  logic [DATA_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_err,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state, state_d;
  logic                  last_b, last_b_d;
  logic                  gnt_b, gnt_b_d;
  logic [7:0]            cnt, cnt_d;
  logic                  pick_b, ready_ok;
  logic                  mem_enable_d, mem_write_d;
  logic [DATA_WIDTH-1:0] mem_addr_d, mem_wdata_d;
  logic                  a_ack_d, a_err_d, b_ack_d, b_err_d;
  logic [DATA_WIDTH-1:0] a_rdata_d, b_rdata_d;

  // Only a strong 1 completes an access; x/z on the ready line is treated as not ready.
  assign ready_ok = (mem_ready === 1'b1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d      = state;
    last_b_d     = last_b;
    gnt_b_d      = gnt_b;
    cnt_d        = cnt;
    pick_b       = b_req && (!a_req || !last_b);
    mem_enable_d = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    a_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    a_rdata_d    = a_rdata;
    b_ack_d      = 1'b0;
    b_err_d      = 1'b0;
    b_rdata_d    = b_rdata;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d      = pick_b;
          last_b_d     = pick_b;
          mem_enable_d = 1'b1;
          mem_write_d  = pick_b && b_write;
          mem_addr_d   = pick_b ? b_addr : a_addr;
          mem_wdata_d  = pick_b ? b_wdata : mem_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ready_ok) begin
          if (gnt_b) begin
            b_ack_d   = 1'b1;
            b_rdata_d = mem_rdata;
          end else begin
            a_ack_d   = 1'b1;
            a_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else if (cnt == CNT_LAST) begin
          if (gnt_b) begin
            b_ack_d   = 1'b1;
            b_err_d   = 1'b1;
            b_rdata_d = '0;
          end else begin
            a_ack_d   = 1'b1;
            a_err_d   = 1'b1;
            a_rdata_d = '0;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_b     <= 1'b1;
      gnt_b      <= 1'b0;
      cnt        <= 8'd0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      a_ack      <= 1'b0;
      a_err      <= 1'b0;
      a_rdata    <= '0;
      b_ack      <= 1'b0;
      b_err      <= 1'b0;
      b_rdata    <= '0;
    end else begin
      last_b     <= last_b_d;
      gnt_b      <= gnt_b_d;
      cnt        <= cnt_d;
      mem_enable <= mem_enable_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      a_ack      <= a_ack_d;
      a_err      <= a_err_d;
      a_rdata    <= a_rdata_d;
      b_ack      <= b_ack_d;
      b_err      <= b_err_d;
      b_rdata    <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, directed requests, expected acks queued and checked by a monitor.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          a_req, b_req, b_write;
  logic [DW-1:0] a_addr, b_addr, b_wdata;
  logic          a_ack, a_err, b_ack, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_enable, mem_write;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic          is_b;
    logic [DW-1:0] rdata;
    logic          err;
    logic [31:0]   cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          enables = 0;
  logic [31:0] cyc = 0;
  int          ready_mode = 0;   // 0 normal, 1 never ready, 2 float ready between accesses
  logic        mem_init = 1'b0;
  logic        prev_en = 1'b0;
  logic [DW-1:0] mem [0:255];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Memory model: reads before it writes, ready/data one cycle after enable.
  always @(posedge clk_in) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem_init   <= 1'b1;
    end else if (mem_enable) begin
      mem_rdata <= mem[mem_addr[7:0]];
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
      mem_ready <= (ready_mode == 1) ? 1'b0 : 1'b1;
    end else begin
      mem_ready <= (ready_mode == 2) ? 1'bz : 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (mem_enable) begin
        enables++;
        check("enable_single_cycle", {31'd0, prev_en}, 32'd0);
      end
      prev_en = mem_enable;
      if (a_ack || b_ack) begin
        if (exp_q.size() == 0) begin
          check("spurious_ack", {30'd0, a_ack, b_ack}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_both", {31'd0, a_ack && b_ack}, 32'd0);
          check("ack_master", {31'd0, b_ack}, {31'd0, e.is_b});
          check("ack_cycle", cyc, e.cyc);
          check("ack_rdata", b_ack ? b_rdata : a_rdata, e.rdata);
          check("ack_err", {31'd0, b_ack ? b_err : a_err}, {31'd0, e.err});
        end
      end
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic push(input logic is_b, input logic [DW-1:0] rd, input logic err, input logic [31:0] c);
    exp_t e;
    e.is_b = is_b; e.rdata = rd; e.err = err; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Waits for every queued ack; drops each master's request after its ack unless hold is set.
  task automatic drain(input bit hold, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_in); #1;
      if (!hold && a_ack) a_req = 1'b0;
      if (!hold && b_ack) b_req = 1'b0;
      n++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
    exp_q.delete();
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic do_req(input logic is_b, input logic wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic err,
                        input int lat);
    @(posedge clk_in); #1;
    if (is_b) begin
      b_req = 1'b1; b_write = wr; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_addr = addr;
    end
    push(is_b, rd, err, cyc + 1 + lat);
    drain(1'b0, lat + 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] base;
    int en0;
    rst_n_in = 1'b0;
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_outputs", {28'd0, a_ack, a_err, b_ack, b_err}, 32'd0);
    check("rst_mem_ctl", {30'd0, mem_enable, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", a_rdata | b_rdata, 32'd0);
    rst_n_in = 1'b1;

    // Single A read: one enable pulse, ack two cycles after grant.
    en0 = enables;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    check("single_read_enables", enables - en0, 32'd1);

    // B write returns the pre-write word, then B reads back the new value.
    do_req(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 2);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 2);
    do_req(1'b1, 1'b1, 32'h30, 32'h0000A5A5, 32'h0, 1'b0, 2);
    do_req(1'b0, 1'b0, 32'h30, 32'h0, 32'h0000A5A5, 1'b0, 2);

    // Both held: A (last grant was A above, but B idle) -> tie order B,A,B,A.
    @(posedge clk_in); #1;
    a_req = 1'b1; a_addr = 32'h10;
    b_req = 1'b1; b_write = 1'b0; b_addr = 32'h20;
    base = cyc;
    push(1'b1, 32'h12345678, 1'b0, base + 3);
    push(1'b0, 32'hDEADBEEF, 1'b0, base + 7);
    push(1'b1, 32'h12345678, 1'b0, base + 11);
    push(1'b0, 32'hDEADBEEF, 1'b0, base + 15);
    drain(1'b1, 30);

    // Timeout with memory never ready.
    ready_mode = 1;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, TO + 1);
    ready_mode = 0;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Reset asserted mid-WAIT; no ack may appear.
    ready_mode = 1;
    @(posedge clk_in); #1;
    a_req = 1'b1; a_addr = 32'h20;
    repeat (5) @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("midrst_acks", {28'd0, a_ack, a_err, b_ack, b_err}, 32'd0);
    check("midrst_a_rdata", a_rdata, 32'd0);
    check("midrst_b_rdata", b_rdata, 32'd0);
    check("midrst_mem_ctl", {30'd0, mem_enable, mem_write}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    a_req = 1'b0;
    ready_mode = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;

    // After reset the aborted access was A, but last grant is B again: A wins the tie.
    @(posedge clk_in); #1;
    a_req = 1'b1; a_addr = 32'h10;
    b_req = 1'b1; b_write = 1'b0; b_addr = 32'h30;
    base = cyc;
    push(1'b0, 32'hDEADBEEF, 1'b0, base + 3);
    push(1'b1, 32'h0000A5A5, 1'b0, base + 7);
    drain(1'b0, 20);

    // Floating ready between accesses must not produce acks.
    ready_mode = 2;
    repeat (10) @(posedge clk_in);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 2);
    repeat (6) @(posedge clk_in);
    ready_mode = 0;
    repeat (2) @(posedge clk_in);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
